booth_acc: RTL

//  Downstream consumer of the 17x17 radix-4 Booth multiplier pipeline.
//  - Tracks issued operands through the multiplier latency with a tag delay line.
//  - Sign-extends each 33-bit product and accumulates it into a dot-product sum.
//  - Presents each completed sum on a valid/ready output port.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_tag_pipe.sv | 46 ++++
 rtl/booth_acc.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier consumer: default widths,
// the per-operand tag carried alongside the multiplier, and product sign extension.
package booth_pkg;

   localparam int PW_DEF  = 33;
   localparam int AW_DEF  = 40;
   localparam int LAT_DEF = 9;
   localparam int CW_DEF  = 8;
   localparam int EXT_W   = 64;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   // Sign-extends the low pw bits of p to EXT_W; callers cast down to their own width.
   function automatic logic [EXT_W-1:0] sext_prod(input logic [EXT_W-1:0] p, input int pw);
      logic [EXT_W-1:0] r;
      for (int i = 0; i < EXT_W; i++) begin
         r[i] = (i < pw) ? p[i] : p[pw-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/booth_tag_pipe.sv
// Tag delay line matching the multiplier latency: a tag written on edge t is
// presented at the tap for the edge t+LAT. Never stalls; reset discards tags.
module booth_tag_pipe
   import booth_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tap,
   output logic any_valid
);

   logic [LAT-1:0] valid_reg;
   logic [LAT-1:0] last_reg;

   generate
      if (LAT == 1) begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg <= '0;
               last_reg  <= '0;
            end else begin
               valid_reg <= tag_in.valid;
               last_reg  <= tag_in.last;
            end
         end
      end else begin : g_shift
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg <= '0;
               last_reg  <= '0;
            end else begin
               valid_reg <= {valid_reg[LAT-2:0], tag_in.valid};
               last_reg  <= {last_reg[LAT-2:0], tag_in.last};
            end
         end
      end
   endgenerate

   assign tap.valid = valid_reg[LAT-1];
   assign tap.last  = last_reg[LAT-1];
   assign any_valid = |valid_reg;

endmodule

// File: rtl/booth_acc.sv
// Dot-product accumulator behind the Booth multiplier with a one-entry valid/ready output.
// Define BOOTH_ACC_SAT_EN to saturate the sum on signed overflow (sticky overflow flag).
module booth_acc
   import booth_pkg::*;
#(
   parameter int PW  = PW_DEF,
   parameter int AW  = AW_DEF,
   parameter int LAT = LAT_DEF,
   parameter int CW  = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic [PW-1:0] product,
   input  logic          acc_clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_data,
   output logic [CW-1:0] out_cnt,
   output logic          busy,
   output logic          lost,
   output logic          overflow
);

   localparam logic ACC_IDLE  = 1'b0;
   localparam logic ACC_RUN   = 1'b1;
   localparam logic OUT_EMPTY = 1'b0;
   localparam logic OUT_FULL  = 1'b1;

   tag_t tag_in;
   tag_t tap;
   logic any_valid;

   logic                 acc_state_reg;
   logic                 out_state_reg;
   logic signed [AW-1:0] acc_reg;
   logic [CW-1:0]        count_reg;
   logic [AW-1:0]        out_data_reg;
   logic [CW-1:0]        out_cnt_reg;
   logic                 lost_reg;

   logic signed [AW-1:0] acc_base;
   logic signed [AW-1:0] prod_ext;
   logic signed [AW-1:0] sum_raw;
   logic signed [AW-1:0] sum_next;
   logic [CW-1:0]        count_base;
   logic [CW-1:0]        cnt_next;
   logic                 term;
   logic                 last_term;
   logic                 accept;
   logic                 load;
   logic                 drop;

   assign tag_in.valid = in_valid;
   assign tag_in.last  = in_last;

   booth_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .tag_in    (tag_in),
      .tap       (tap),
      .any_valid (any_valid)
   );

   assign term      = tap.valid;
   assign last_term = tap.valid & tap.last;

   // A term arriving with acc_clr starts a fresh sum instead of adding to the old one.
   assign acc_base   = acc_clr ? '0 : acc_reg;
   assign count_base = acc_clr ? '0 : count_reg;
   assign prod_ext   = AW'(sext_prod(EXT_W'(product), PW));
   assign sum_raw    = acc_base + prod_ext;
   assign cnt_next   = (count_base == {CW{1'b1}}) ? count_base : count_base + CW'(1);

`ifdef BOOTH_ACC_SAT_EN
   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   logic sum_ovf;
   logic overflow_reg;

   assign sum_ovf  = (acc_base[AW-1] == prod_ext[AW-1]) && (sum_raw[AW-1] != acc_base[AW-1]);
   assign sum_next = sum_ovf ? (acc_base[AW-1] ? ACC_MIN : ACC_MAX) : sum_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_reg <= 1'b0;
      end else begin
         if (acc_clr) overflow_reg <= 1'b0;
         if (term && sum_ovf) overflow_reg <= 1'b1;
      end
   end

   assign overflow = overflow_reg;
`else
   assign sum_next = sum_raw;
   assign overflow = 1'b0;
`endif

   assign accept = (out_state_reg == OUT_FULL) & out_ready;
   assign load   = last_term & ((out_state_reg == OUT_EMPTY) | accept);
   assign drop   = last_term & ~load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg       <= '0;
         count_reg     <= '0;
         acc_state_reg <= ACC_IDLE;
      end else if (term && !tap.last) begin
         acc_reg       <= sum_next;
         count_reg     <= cnt_next;
         acc_state_reg <= ACC_RUN;
      end else if (term || acc_clr) begin
         acc_reg       <= '0;
         count_reg     <= '0;
         acc_state_reg <= ACC_IDLE;
      end
   end

   // The output register only changes on a load, so it stays stable while FULL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_state_reg <= OUT_EMPTY;
         out_data_reg  <= '0;
         out_cnt_reg   <= '0;
      end else if (load) begin
         out_state_reg <= OUT_FULL;
         out_data_reg  <= sum_next;
         out_cnt_reg   <= cnt_next;
      end else if (accept) begin
         out_state_reg <= OUT_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost_reg <= 1'b0;
      end else begin
         if (acc_clr) lost_reg <= 1'b0;
         if (drop) lost_reg <= 1'b1;
      end
   end

   assign out_valid = (out_state_reg == OUT_FULL);
   assign out_data  = out_data_reg;
   assign out_cnt   = out_cnt_reg;
   assign lost      = lost_reg;
   assign busy      = any_valid | (acc_state_reg == ACC_RUN);

endmodule
